// File: rtl/sv_encoder_step_gen.sv
// Quadrature encoder front end: synchronizes and glitch-filters A/B, x4-decodes a
// signed position, and emits a one-cycle step pulse every N counts with backlash memory.
module sv_encoder_step_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int POS_WIDTH   = 32,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 enc_a_input,
  input  logic                 enc_b_input,
  input  logic                 i_enable,
  input  logic                 i_dir_sel,
  input  logic [DIV_WIDTH-1:0] i_step_div,
  input  logic                 i_pos_clear,
  output logic [POS_WIDTH-1:0] o_position,
  output logic                 o_direction,
  output logic                 o_step,
  output logic                 o_error
);

  localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
  localparam int FW     = $clog2(FILTER_LEN + 1);
  localparam int SW     = $clog2(SETTLE + 1);
  localparam int AW     = DIV_WIDTH + 1;

  // Most negative accumulator value: -(2^DIV_WIDTH - 1)
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] ACC_ONE = AW'(1);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [1:0]             synced;
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             prev_q;
  logic [FW-1:0]          fcnt_q [2];
  logic [FW-1:0]          fcnt_d [2];
  logic [SW-1:0]          settle_q, settle_d;
  logic                   settling;

  logic                   fwd, rev, illegal, sel, opp;
  logic [DIV_WIDTH-1:0]   div_m1;
  logic signed [AW-1:0]   div_m1_s;

  logic [POS_WIDTH-1:0]   pos_q, pos_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   dsel_q;

  assign synced   = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign settling = (settle_q != SW'(SETTLE));
  assign settle_d = settling ? settle_q + SW'(1) : settle_q;

  // A changed level must be seen on FILTER_LEN+1 consecutive samples to flip the
  // filtered line, which gives the pin-to-position latency of SYNC_STAGES+FILTER_LEN+1.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (settling) begin
        filt_d[i] = synced[i];
      end else if (synced[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_LEN)) filt_d[i] = synced[i];
        else                               fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  // Forward order on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    illegal = 1'b0;
    if (!settling) begin
      fwd = (prev_q == 2'b00 && filt_q == 2'b10) || (prev_q == 2'b10 && filt_q == 2'b11) ||
            (prev_q == 2'b11 && filt_q == 2'b01) || (prev_q == 2'b01 && filt_q == 2'b00);
      rev = (filt_q == 2'b00 && prev_q == 2'b10) || (filt_q == 2'b10 && prev_q == 2'b11) ||
            (filt_q == 2'b11 && prev_q == 2'b01) || (filt_q == 2'b01 && prev_q == 2'b00);
      illegal = ((prev_q ^ filt_q) == 2'b11);
    end
  end

  assign div_m1   = (i_step_div == '0) ? '0 : i_step_div - DIV_WIDTH'(1);
  assign div_m1_s = $signed({1'b0, div_m1});
  assign sel      = i_dir_sel ? rev : fwd;
  assign opp      = i_dir_sel ? fwd : rev;

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    err_d  = err_q;
    acc_d  = acc_q;
    step_d = 1'b0;
    if (fwd) begin
      pos_d = pos_q + POS_WIDTH'(1);
      dir_d = 1'b0;
    end else if (rev) begin
      pos_d = pos_q - POS_WIDTH'(1);
      dir_d = 1'b1;
    end
    if (illegal) err_d = 1'b1;
    if (!i_enable || (i_dir_sel != dsel_q)) begin
      acc_d = '0;
    end else if (sel) begin
      if (acc_q >= div_m1_s) begin
        step_d = 1'b1;
        acc_d  = '0;
      end else begin
        acc_d = acc_q + ACC_ONE;
      end
    end else if (opp && (acc_q != ACC_MIN)) begin
      acc_d = acc_q - ACC_ONE;
    end
    // Clear drops any coincident count entirely, including its direction update.
    if (i_pos_clear) begin
      pos_d  = '0;
      acc_d  = '0;
      err_d  = 1'b0;
      step_d = 1'b0;
      dir_d  = dir_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      fcnt_q   <= '{default: '0};
      settle_q <= '0;
      pos_q    <= '0;
      acc_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      dsel_q   <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a_input};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b_input};
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      fcnt_q   <= fcnt_d;
      settle_q <= settle_d;
      pos_q    <= pos_d;
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      dsel_q   <= i_dir_sel;
    end
  end

  assign o_position  = pos_q;
  assign o_direction = dir_q;
  assign o_step      = step_q;
  assign o_error     = err_q;

endmodule

// File: tb/tb_sv_encoder_step_gen.sv
// Scoreboard bench for sv_encoder_step_gen: a quadrature-level model predicts position,
// direction, error and step positions; an 8-bit-position instance checks wraparound.
module tb_sv_encoder_step_gen;

  localparam int DW   = 16;
  localparam int FLEN = 4;

  logic          clk = 1'b0;
  logic          rst, a, b, en, dsel, clr;
  logic [DW-1:0] div;
  logic [31:0]   pos32;
  logic          dir32, step32, err32;
  logic [7:0]    pos8;
  logic          dir8, step8, err8;

  always #5 clk = ~clk;

  sv_encoder_step_gen #(.SYNC_STAGES(2), .FILTER_LEN(FLEN), .POS_WIDTH(32), .DIV_WIDTH(DW)) u_dut (
    .i_clk(clk), .i_reset(rst), .enc_a_input(a), .enc_b_input(b), .i_enable(en),
    .i_dir_sel(dsel), .i_step_div(div), .i_pos_clear(clr),
    .o_position(pos32), .o_direction(dir32), .o_step(step32), .o_error(err32));

  sv_encoder_step_gen #(.SYNC_STAGES(2), .FILTER_LEN(FLEN), .POS_WIDTH(8), .DIV_WIDTH(DW)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .enc_a_input(a), .enc_b_input(b), .i_enable(en),
    .i_dir_sel(dsel), .i_step_div(div), .i_pos_clear(clr),
    .o_position(pos8), .o_direction(dir8), .o_step(step8), .o_error(err8));

  int n_checks = 0;
  int n_fail   = 0;
  int n_steps  = 0;

  typedef struct packed {
    logic [31:0] pos;
    logic        err;
    logic        dir;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] step_q[$];

  logic [31:0] m_pos;
  int          m_acc;
  logic        m_err, m_dir;
  logic [1:0]  m_ab;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] nf(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] pf(input logic [1:0] s);
    case (s)
      2'b10:   return 2'b00;
      2'b11:   return 2'b10;
      2'b01:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int dq(input logic [1:0] p, input logic [1:0] c);
    if (p == c)     return 0;
    if (nf(p) == c) return 1;
    if (nf(c) == p) return -1;
    return 2;
  endfunction

  task automatic model_apply(input int d);
    int  de;
    bit  s;
    if (d == 2) begin
      m_err = 1'b1;
    end else if (d != 0) begin
      m_pos = m_pos + 32'(d);
      m_dir = (d < 0);
    end
    de = (div == '0) ? 1 : int'(div);
    if (!en) begin
      m_acc = 0;
    end else if (d == 1 || d == -1) begin
      s = dsel ? (d < 0) : (d > 0);
      if (s) begin
        if (m_acc >= de - 1) begin
          step_q.push_back(m_pos);
          m_acc = 0;
        end else begin
          m_acc++;
        end
      end else if (m_acc > -((1 << DW) - 1)) begin
        m_acc--;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.pos = m_pos;
    e.err = m_err;
    e.dir = m_dir;
    exp_q.push_back(e);
  endtask

  task automatic compare_exp(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    check({tag, "_pos"}, 64'(pos32), 64'(e.pos));
    check({tag, "_err"}, 64'(err32), 64'(e.err));
    check({tag, "_dir"}, 64'(dir32), 64'(e.dir));
    check({tag, "_step_missing"}, 64'(step_q.size()), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (step32 === 1'b1) begin
      n_steps++;
      if (step_q.size() == 0) check("step_unexpected", 64'(step32), 64'd0);
      else                    check("step_pos", 64'(pos32), 64'(step_q.pop_front()));
    end
  endtask

  task automatic move(input logic [1:0] nab, input int hold, input bit measure);
    logic [31:0] start;
    int          lat;
    model_apply(dq(m_ab, nab));
    m_ab = nab;
    push_exp();
    a     = nab[1];
    b     = nab[0];
    start = pos32;
    lat   = -1;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (lat < 0 && pos32 !== start) lat = i - 1;
    end
    if (measure) check("latency", 64'(lat), 64'd7);
    compare_exp("move");
  endtask

  task automatic fwd_n(input int n, input int hold);
    for (int i = 0; i < n; i++) move(nf(m_ab), hold, 1'b0);
  endtask

  task automatic rev_n(input int n, input int hold);
    for (int i = 0; i < n; i++) move(pf(m_ab), hold, 1'b0);
  endtask

  task automatic pulse_a(input int len);
    logic [1:0] orig, t;
    orig = m_ab;
    t    = {~orig[1], orig[0]};
    if (len > FLEN) begin
      model_apply(dq(orig, t));
      model_apply(dq(t, orig));
    end
    push_exp();
    a = t[1];
    repeat (len) tick();
    a = orig[1];
    repeat (15) tick();
    compare_exp("glitch");
  endtask

  task automatic do_clear();
    m_pos = '0;
    m_acc = 0;
    m_err = 1'b0;
    push_exp();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    compare_exp("clear");
  endtask

  task automatic clear_with_count();
    m_ab  = nf(m_ab);
    m_pos = '0;
    m_acc = 0;
    m_err = 1'b0;
    push_exp();
    a = m_ab[1];
    b = m_ab[0];
    repeat (7) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    compare_exp("clr_count");
  endtask

  task automatic do_reset();
    step_q.delete();
    exp_q.delete();
    rst = 1'b1;
    tick();
    check("rst_pos",  64'(pos32),  64'd0);
    check("rst_pos8", 64'(pos8),   64'd0);
    check("rst_dir",  64'(dir32),  64'd0);
    check("rst_step", 64'(step32), 64'd0);
    check("rst_err",  64'(err32),  64'd0);
    rst   = 1'b0;
    m_pos = '0;
    m_acc = 0;
    m_err = 1'b0;
    m_dir = 1'b0;
    m_ab  = {a, b};
    push_exp();
    repeat (20) tick();
    compare_exp("settle");
  endtask

  task automatic set_dsel(input logic v);
    dsel  = v;
    m_acc = 0;
    repeat (3) tick();
  endtask

  initial begin
    int s0;
    rst = 1'b1; a = 1'b1; b = 1'b1; en = 1'b1; dsel = 1'b0; div = DW'(4); clr = 1'b0;
    m_ab = 2'b11;
    repeat (2) tick();
    do_reset();

    // forward run, div=4: latency on the first edge, then steps at 4/8/12/16
    s0 = n_steps;
    move(nf(m_ab), 10, 1'b1);
    fwd_n(15, 10);
    check("fwd_pos",   64'(pos32),         64'd16);
    check("fwd_steps", 64'(n_steps - s0),  64'd4);

    pulse_a(3);
    pulse_a(5);

    // backlash with div=2
    do_clear();
    div = DW'(2);
    s0  = n_steps;
    rev_n(3, 10);
    fwd_n(4, 10);
    check("backlash_nostep", 64'(n_steps - s0), 64'd0);
    fwd_n(1, 10);
    check("backlash_step", 64'(n_steps - s0), 64'd1);
    check("backlash_pos",  64'(pos32),        64'd2);

    // reverse-selected steps, div=1
    set_dsel(1'b1);
    div = DW'(1);
    rev_n(2, 10);
    set_dsel(1'b0);

    // illegal transition and sticky error
    while (m_ab != 2'b00) fwd_n(1, 10);
    move(2'b11, 10, 1'b0);
    check("illegal_err", 64'(err32), 64'd1);
    fwd_n(2, 10);
    do_clear();

    // disabled stepping, then 8-bit wrap
    en    = 1'b0;
    m_acc = 0;
    s0    = n_steps;
    fwd_n(10, 9);
    check("dis_pos",   64'(pos32),        64'd10);
    check("dis_steps", 64'(n_steps - s0), 64'd0);
    fwd_n(117, 9);
    check("wrap_127", 64'(pos8), 64'(m_pos[7:0]));
    fwd_n(1, 9);
    check("wrap_neg", 64'(pos8),  64'h80);
    check("wrap_32",  64'(pos32), 64'd128);
    en = 1'b1;
    repeat (2) tick();

    // clear coincident with a count that would step
    div = DW'(1);
    fwd_n(1, 10);
    clear_with_count();

    // reset while a transition is in flight
    fwd_n(3, 10);
    a = nf(m_ab)[1];
    b = nf(m_ab)[0];
    repeat (3) tick();
    do_reset();
    fwd_n(4, 10);

    check("step_queue_empty", 64'(step_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/sv_encoder_step_gen.md
# sv_encoder_step_gen

Quadrature encoder front end that turns raw A/B encoder lines into a filtered signed position count and a one-cycle step pulse every N encoder counts. Sits directly upstream of the trigger generator: `o_step` drives its `encoder_step_input`, and `i_enable` mirrors its `en_enc_input`. Handles metastability, contact/EMI glitches, illegal quadrature transitions and backlash, so the trigger stage sees clean single-cycle steps only.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per encoder line (≥2)
- `FILTER_LEN`, 4: consecutive cycles a changed level must persist before it is accepted (≥1)
- `POS_WIDTH`, 32: width of the signed position counter
- `DIV_WIDTH`, 16: width of the step divider value

- `i_clk` in 1: single clock for the whole block
- `i_reset` in 1: synchronous, active-high reset
- `enc_a_input` in 1: encoder channel A, asynchronous
- `enc_b_input` in 1: encoder channel B, asynchronous
- `i_enable` in 1: step generation enable
- `i_dir_sel` in 1: step direction; 0 = forward counts produce steps, 1 = reverse counts
- `i_step_div` in DIV_WIDTH: counts per step; 0 is treated as 1
- `i_pos_clear` in 1: one-cycle clear of position, divider accumulator and error
- `o_position` out POS_WIDTH: signed x4-decoded position
- `o_direction` out 1: direction of the last legal count; 1 = reverse
- `o_step` out 1: one-cycle step pulse
- `o_error` out 1: sticky illegal-transition flag

## Operation
- **Synchronizer.** A and B each pass through SYNC_STAGES flops.
- **Glitch filter, per line.**
  - A counter increments while synced ≠ filtered and clears when they are equal.
  - The filtered level flips on the cycle the counter reaches FILTER_LEN.
  - Pulses shorter than FILTER_LEN cycles never reach the decoder.
- **Settle window.**
  - For SYNC_STAGES+FILTER_LEN cycles after reset deasserts, filtered values load directly from synced values.
  - No counts and no errors occur during this window, so a nonzero idle A/B state is not a false transition.
- **Decoder.**
  - Compares the previous and current filtered {A,B}.
  - Forward (A leads B): 00→10→11→01→00. Each legal step is +1 and sets `o_direction`=0.
  - Reverse sequence: −1, and sets `o_direction`=1.
  - No change: nothing happens.
  - Both bits change in the same cycle: no count, `o_error` set. It stays set until `i_reset` or `i_pos_clear`.
- **Position.** `o_position` is always updated regardless of `i_enable`, and wraps modulo 2^POS_WIDTH.
- **Divider.** Signed accumulator of DIV_WIDTH+1 bits.
  - Count in the selected direction: if acc ≥ div−1, pulse `o_step` and set acc=0; otherwise acc+1.
  - Count in the opposite direction: acc−1, saturating at −(2^DIV_WIDTH−1). This is backlash memory: after R opposite counts, R+div selected counts are needed for the next step.
  - `i_enable`=0: acc is forced to 0 and `o_step` stays 0.
- **Clear.** `i_pos_clear` zeroes position, acc and error on the next edge. It wins over a simultaneous count, and that count is dropped.
- **Runtime changes.**
  - `i_step_div` changes take effect on the next count. If acc already ≥ new div−1, the next selected count fires a step.
  - An `i_dir_sel` change resets acc to 0.

## Timing
- **Reset values:** `o_position`=0, `o_direction`=0, `o_step`=0, `o_error`=0. The synchronizer, filters, counters and acc are all 0.
- **Latency.** A pin edge stable before clock edge k updates `o_position` at edge k+SYNC_STAGES+FILTER_LEN+1 (7 with defaults).
- **Step alignment.** `o_step` is registered and asserts in the same cycle as the position update that caused it, for exactly one cycle.
- **Throughput.**
  - At most one count per cycle.
  - Guaranteed detection requires each quadrature state to last more than FILTER_LEN cycles.
  - Consecutive steps are at least div counts apart; with div=1, every selected count produces a step.
- **Reset mid-operation.** `i_reset` asserted at any cycle aborts everything on the next edge. The settle window restarts after deassert.

## Test plan
- **Forward steps.** Reset, A/B idle at 11, default parameters, div=4, enable=1, dir_sel=0; 16 forward quadrature states, 10 cycles each → no count during settle; position=16, exactly 4 `o_step` pulses, each 1 cycle, aligned with position 4/8/12/16; error=0.
- **Glitch rejection.** With A/B stable, a 3-cycle pulse on A → position, step and error unchanged. A 5-cycle pulse on A → +1 then −1, position back to start.
- **Illegal transition.** Drive 00→11 in one cycle → no count, error=1 and remains set. `i_pos_clear` → error=0, position=0.
- **Backlash.** div=2, 3 reverse counts then forward counts → acc reaches −3; first step only on the 5th forward count; position=+2.
- **Enable and wrap.** `i_enable`=0 with 10 forward counts → position +10, no steps. POS_WIDTH=8 build, position 127 plus one forward count → −128.
- **Mid-run reset and clear priority.** `i_reset` pulsed mid-sequence → all outputs 0 next cycle. `i_pos_clear` coincident with a count → position=0, no step.
